instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Instruction fetch stage; the producer for control_unit's inst input. Holds the PC,
//  fetches words from instruction memory over a req/ack handshake, buffers up to 2
//  fetched words, and presents inst with a valid/ready handshake.
//  Consumes control_unit's PCen (stall) and PCSrc (redirect) to steer the PC.
// PARAMETERS
//  SIZE      32   datapath/address width in bits
//  RESET_PC  0    first fetch address after reset; bits [1:0] must be 0
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst_n          in   1     asynchronous active-low reset
//  PCen           in   1     1=advance; 0=stall (no new fetch, no pop, no redirect)
//  PCSrc          in   1     redirect request; acted on only when PCen=1
//  branch_target  in   SIZE  redirect address; bits [1:0] forced to 0 internally
//  imem_req       out  1     fetch request, registered
//  imem_addr      out  SIZE  fetch address, registered, stable while imem_req=1
//  imem_ack       in   1     memory accepts req and returns data this cycle
//  imem_rdata     in   SIZE  fetched word, valid when imem_req & imem_ack
//  inst           out  SIZE  buffer head instruction
//  inst_valid     out  1     buffer non-empty
//  inst_ready     in   1     decoder accepts head
//  pc_out         out  SIZE  address of inst
// BEHAVIOUR
//  Reset (async): imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, buffer empty,
//   inst=0, inst_valid=0, pc_out=RESET_PC, squash=0. In-flight request dropped.
//  Buffer: 2-entry FIFO of {pc, word}. Pop = inst_valid & inst_ready & PCen.
//   inst/pc_out show head (0/last popped pc when empty are don't-care; tests check valid only).
//  Transfer: word written on edge where imem_req & imem_ack & !squash & !redirect.
//   At most one outstanding request; imem_req stays high, imem_addr unchanged, until ack.
//  Issue rule: when imem_req=0 or acked this edge, next imem_req=1 iff PCen=1 and
//   occupancy after this edge's write/pop/flush is <2; imem_addr=fetch_pc.
//   On accepted (acked, unsquashed) fetch: fetch_pc <= fetch_pc+4, modulo 2^SIZE
//   (0xFFFFFFFC wraps to 0x0).
//  Latency: req at cycle N with ack at N -> inst_valid at N+1. Sustained 1 inst/cycle
//   with ack=1 and inst_ready=1.
//  Redirect (PCSrc & PCen at edge): buffer flushed (inst_valid=0 next cycle),
//   fetch_pc <= {branch_target[SIZE-1:2],2'b00}. Flush beats same-edge write and pop.
//   - ack same edge: returned word discarded; next req to target next cycle.
//   - req pending, no ack: squash=1, req/addr held; on ack word discarded, squash=0,
//     target requested the following cycle (req may stay high, addr changes).
//   - second redirect while squash=1: fetch_pc updated again, squash stays 1.
//  Stall (PCen=0): no pop, no new issue, no redirect; pending request completes and its
//   word is written if space was reserved.
//  Buffer never overflows: issue rule reserves the slot; write into full buffer is a bug.
//  FSM: IDLE (no req) -> REQ on issue; REQ -> REQ on ack & issue, IDLE on ack & !issue;
//   REQ holds on !ack. squash is an orthogonal flag cleared on ack.
// TESTING
//  1 Reset release, ack tied 1, ready 1, PCen 1 -> addrs 0,4,8,..; inst_valid from 2nd cycle, one per cycle.
//  2 ready=0 for 5 cycles -> exactly 2 words buffered, imem_req=0 after; ready=1 -> drain in order 0x0,0x4.
//  3 PCSrc=1, target 0x103 with buffer full -> flushed, next imem_addr=0x100, next inst pc_out=0x100.
//  4 ack delayed 3 cycles, PCSrc at cycle 1, target 0x40 -> addr held until ack, word dropped, then req 0x40.
//  5 PCen=0 mid-stream -> no pops, no new req, PCSrc ignored; PCen=1 resumes at correct next pc.
//  6 RESET_PC=0xFFFFFFF8 -> fetches 0xFFFFFFF8,0xFFFFFFFC,0x0; rst_n low mid-request -> all outputs reset immediately.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// buffers up to two {pc, word} entries and hands them to the decoder with valid/ready.
module instruction_fetch #(
    parameter int              SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCen,
    input  logic            PCSrc,
    input  logic [SIZE-1:0] branch_target,
    output logic            imem_req,
    output logic [SIZE-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [SIZE-1:0] imem_rdata,
    output logic [SIZE-1:0] inst,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [SIZE-1:0] pc_out
);

    typedef enum logic {IDLE, REQ} fetchState_t;

    fetchState_t     state;
    fetchState_t     stateNext;
    logic [SIZE-1:0] fetchPc;
    logic [SIZE-1:0] fetchPcNext;
    logic            squash;
    logic            squashNext;
    logic [SIZE-1:0] bufPc   [2];
    logic [SIZE-1:0] bufWord [2];
    logic            rdPtr;
    logic            wrPtr;
    logic [1:0]      count;
    logic [1:0]      countNext;
    logic [SIZE-1:0] redirectTarget;
    logic            redirect;
    logic            acked;
    logic            doWrite;
    logic            doPop;
    logic            issuePoint;
    logic            issue;

    // Word alignment is enforced by clearing the two low address bits.
    assign redirectTarget = branch_target & ~SIZE'(3);

    assign imem_req   = (state == REQ);
    assign inst_valid = (count != 2'd0);
    assign inst       = bufWord[rdPtr];
    assign pc_out     = bufPc[rdPtr];

    // Next-state, handshake events and the issue decision for this edge.
    always_comb begin
        redirect    = PCSrc & PCen;
        acked       = (state == REQ) & imem_ack;
        // A squashed or redirected return never reaches the buffer.
        doWrite     = acked & ~squash & ~redirect;
        doPop       = inst_valid & inst_ready & PCen;
        countNext   = count;
        fetchPcNext = fetchPc;
        squashNext  = squash;
        stateNext   = state;
        issue       = 1'b0;

        // Flush beats any same-edge write or pop.
        if (redirect) begin
            countNext = 2'd0;
        end else begin
            countNext = count + {1'b0, doWrite} - {1'b0, doPop};
        end

        if (redirect) begin
            fetchPcNext = redirectTarget;
        end else if (acked && !squash) begin
            fetchPcNext = fetchPc + SIZE'(4);
        end

        // A redirect that catches a request still in flight marks its return as stale.
        if (acked) begin
            squashNext = 1'b0;
        end else if (redirect && state == REQ) begin
            squashNext = 1'b1;
        end

        // A new request may only go out when the bus is free, and it reserves a buffer slot.
        issuePoint = (state == IDLE) | acked;
        issue      = issuePoint & PCen & (countNext < 2'd2);
        if (issuePoint) begin
            stateNext = issue ? REQ : IDLE;
        end
    end

    // FSM state, fetch PC, squash flag and the request address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetchPc   <= RESET_PC;
            squash    <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
            squash  <= squashNext;
            if (issue) begin
                imem_addr <= fetchPcNext;
            end
        end
    end

    // Two-entry FIFO of fetched {pc, word}; pointers rewind on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                bufPc[i]   <= RESET_PC;
                bufWord[i] <= '0;
            end
        end else begin
            count <= countNext;
            if (redirect) begin
                rdPtr <= 1'b0;
                wrPtr <= 1'b0;
            end else begin
                if (doWrite) begin
                    bufPc[wrPtr]   <= imem_addr;
                    bufWord[wrPtr] <= imem_rdata;
                    wrPtr          <= ~wrPtr;
                end
                if (doPop) begin
                    rdPtr <= ~rdPtr;
                end
            end
        end
    end

endmodule
